// File: rtl/tabla_checker.sv
// Truth-table response checker: sweeps every input vector onto a DUT, samples y_in and compares it against EXPECTED.
// Optional build macro TABLA_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module tabla_checker #(
  parameter int                      N_IN     = 3,
  parameter logic [(1<<N_IN)-1:0]    EXPECTED = 8'b11101000,
  parameter int                      SETTLE   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   y_in,
  output logic [N_IN-1:0]        abc_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_count,
  output logic                   fail_valid,
  output logic [N_IN-1:0]        first_fail,
  output logic [(1<<N_IN)-1:0]   observed
);

  localparam logic [7:0]      SETTLE_C = 8'(SETTLE);
  localparam logic [N_IN-1:0] LAST     = '1;

  typedef enum logic [1:0] {IDLE, SETTLING, SAMPLE, FINISH} state_t;

  state_t          state;
  logic [7:0]      cnt;
  logic            mismatch;
  logic            last_vec;
  logic            end_sweep;
  logic [N_IN:0]   err_next;

  assign mismatch = (y_in != EXPECTED[abc_out]);
  assign last_vec = (abc_out == LAST);
  assign err_next = err_count + {{N_IN{1'b0}}, mismatch};

`ifdef TABLA_STOP_ON_FAIL_EN
  assign end_sweep = last_vec || mismatch;
`else
  assign end_sweep = last_vec;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      abc_out    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
      observed   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            abc_out    <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
            observed   <= '0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            cnt        <= SETTLE_C;
            state      <= (SETTLE_C == 8'd0) ? SAMPLE : SETTLING;
          end
        end
        SETTLING: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) state <= SAMPLE;
        end
        SAMPLE: begin
          observed[abc_out] <= y_in;
          err_count         <= err_next;
          if (mismatch && !fail_valid) begin
            first_fail <= abc_out;
            fail_valid <= 1'b1;
          end
          // pass is decided from the count including this last sample
          if (end_sweep) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_next == '0);
            state <= FINISH;
          end else begin
            abc_out <= abc_out + 1'b1;
            cnt     <= SETTLE_C;
            state   <= (SETTLE_C == 8'd0) ? SAMPLE : SETTLING;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tabla_checker.sv
// Directed bench for tabla_checker: three instances (SETTLE 1, 3, 0) each driven by a behavioural gate model.
module tb_tabla_checker;

  localparam int         NV  = 8;
  localparam logic [7:0] EXP = 8'b11101000;

  typedef struct {
    logic [7:0] obs;
    logic [3:0] err;
    logic [2:0] ff;
    logic       fv;
    logic       pass;
    int         cycles;
    logic [2:0] last;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] start;
  logic [2:0] y;
  logic [1:0] mode;
  logic [2:0] abc [3];
  logic [2:0] busy, done, pass, fv;
  logic [3:0] errc [3];
  logic [2:0] ff [3];
  logic [7:0] obs [3];

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic [3:0] last_err;

  always #5 clk = ~clk;

  // mode 0: majority, 1: majority with vector 5 inverted, 2: inverted majority
  function automatic logic y_model(input logic [1:0] m, input logic [2:0] idx);
    logic maj;
    maj = (int'(idx[0]) + int'(idx[1]) + int'(idx[2])) >= 2;
    case (m)
      2'd1:    return (idx == 3'd5) ? ~maj : maj;
      2'd2:    return ~maj;
      default: return maj;
    endcase
  endfunction

  assign y[0] = y_model(mode, abc[0]);
  assign y[1] = y_model(mode, abc[1]);
  assign y[2] = y_model(mode, abc[2]);

  tabla_checker #(.N_IN(3), .EXPECTED(EXP), .SETTLE(1)) u_s1 (
    .clk(clk), .reset(reset), .start(start[0]), .y_in(y[0]), .abc_out(abc[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]),
    .fail_valid(fv[0]), .first_fail(ff[0]), .observed(obs[0]));

  tabla_checker #(.N_IN(3), .EXPECTED(EXP), .SETTLE(3)) u_s3 (
    .clk(clk), .reset(reset), .start(start[1]), .y_in(y[1]), .abc_out(abc[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errc[1]),
    .fail_valid(fv[1]), .first_fail(ff[1]), .observed(obs[1]));

  tabla_checker #(.N_IN(3), .EXPECTED(EXP), .SETTLE(0)) u_s0 (
    .clk(clk), .reset(reset), .start(start[2]), .y_in(y[2]), .abc_out(abc[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(errc[2]),
    .fail_valid(fv[2]), .first_fail(ff[2]), .observed(obs[2]));

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_vec++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic int settle_of(input int i);
    case (i)
      1:       return 3;
      2:       return 0;
      default: return 1;
    endcase
  endfunction

  task automatic push_exp(input int i, input logic [1:0] m);
    exp_t e;
    int   s;
    int   nrun;
    s = settle_of(i);
    e.obs = '0; e.err = '0; e.ff = '0; e.fv = 1'b0; nrun = NV;
    for (int v = 0; v < NV; v++) begin
      logic yb;
      yb = y_model(m, 3'(v));
      e.obs[v] = yb;
      if (yb !== EXP[v]) begin
        e.err = e.err + 4'd1;
        if (!e.fv) begin
          e.fv = 1'b1;
          e.ff = 3'(v);
        end
`ifdef TABLA_STOP_ON_FAIL_EN
        nrun = v + 1;
        break;
`endif
      end
    end
    e.pass   = (e.err == 4'd0);
    e.cycles = nrun * (s + 1);
    e.last   = 3'(nrun - 1);
    sb.push_back(e);
  endtask

  // Entered #1 after the start-acceptance edge; follows the sweep until done and scores it.
  task automatic track(input int i, input int pulse_at);
    int   s;
    int   k;
    exp_t e;
    s = settle_of(i);
    k = 0;
    while (!done[i] && k <= 600) begin
      chk($sformatf("abc_i%0d_k%0d", i, k), 32'(abc[i]), 32'(k / (s + 1)));
      @(posedge clk); #1;
      k++;
      if (k == pulse_at) start[i] = 1'b1;
      else if (k == pulse_at + 1) start[i] = 1'b0;
    end
    if (!done[i]) begin
      chk($sformatf("timeout_i%0d", i), 32'(done[i]), 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    last_err = e.err;
    chk($sformatf("cycles_i%0d", i), 32'(k), 32'(e.cycles));
    chk($sformatf("abc_done_i%0d", i), 32'(abc[i]), 32'(e.last));
    chk($sformatf("observed_i%0d", i), 32'(obs[i]), 32'(e.obs));
    chk($sformatf("err_count_i%0d", i), 32'(errc[i]), 32'(e.err));
    chk($sformatf("first_fail_i%0d", i), 32'(ff[i]), 32'(e.ff));
    chk($sformatf("fail_valid_i%0d", i), 32'(fv[i]), 32'(e.fv));
    chk($sformatf("pass_i%0d", i), 32'(pass[i]), 32'(e.pass));
    chk($sformatf("busy_done_i%0d", i), 32'(busy[i]), 32'd0);
    @(posedge clk); #1;
    chk($sformatf("done_pulse_i%0d", i), 32'(done[i]), 32'd0);
  endtask

  task automatic sweep(input int i, input logic [1:0] m, input int pulse_at);
    mode = m;
    push_exp(i, m);
    @(negedge clk);
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
    track(i, pulse_at);
  endtask

  task automatic chk_zero(input string tag, input int i);
    chk({tag, "_abc"},  32'(abc[i]),  32'd0);
    chk({tag, "_busy"}, 32'(busy[i]), 32'd0);
    chk({tag, "_done"}, 32'(done[i]), 32'd0);
    chk({tag, "_pass"}, 32'(pass[i]), 32'd0);
    chk({tag, "_err"},  32'(errc[i]), 32'd0);
    chk({tag, "_fv"},   32'(fv[i]),   32'd0);
    chk({tag, "_ff"},   32'(ff[i]),   32'd0);
    chk({tag, "_obs"},  32'(obs[i]),  32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = '0;
    mode  = 2'd0;
    last_err = '0;
    #12;
    chk_zero("reset", 0);
    @(negedge clk);
    reset = 1'b0;

    sweep(0, 2'd0, -1);
    sweep(0, 2'd1, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold_err", 32'(errc[0]), 32'(last_err));
    sweep(0, 2'd2, -1);

    // asynchronous reset in vector 3's settle cycle
`ifdef TABLA_STOP_ON_FAIL_EN
    mode = 2'd0;
`else
    mode = 2'd2;
`endif
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk("pre_reset_abc", 32'(abc[0]), 32'd3);
    #1;
    reset = 1'b1;
    #1;
    chk_zero("async_reset", 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_busy", 32'(busy[0]), 32'd0);
    sweep(0, 2'd0, -1);

    // start pulse at vector 2 must be ignored
    sweep(0, 2'd0, 4);

    // start held across DONE: restarts after the following idle cycle
    mode = 2'd0;
    push_exp(0, 2'd0);
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk); #1;
    track(0, -1);
    chk("held_start_idle_busy", 32'(busy[0]), 32'd0);
    push_exp(0, 2'd0);
    @(posedge clk); #1;
    start[0] = 1'b0;
    chk("held_start_restart_busy", 32'(busy[0]), 32'd1);
    track(0, -1);

    sweep(1, 2'd0, -1);
    sweep(1, 2'd1, -1);
    sweep(2, 2'd0, -1);
    sweep(2, 2'd2, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
